// File: rtl/ahbl_splitter_if.sv
// Bus bundle for the 1:N AHB-Lite splitter: upstream master port plus packed
// per-port downstream slave signals. The splitter uses the slave modport.
interface ahbl_splitter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic                    src_hready;
    logic                    src_hready_resp;
    logic                    src_hresp;
    logic [W_ADDR-1:0]       src_haddr;
    logic                    src_hwrite;
    logic [1:0]              src_htrans;
    logic [2:0]              src_hsize;
    logic [2:0]              src_hburst;
    logic [3:0]              src_hprot;
    logic                    src_hmastlock;
    logic [W_DATA-1:0]       src_hwdata;
    logic [W_DATA-1:0]       src_hrdata;
    logic                    src_hexcl;
    logic [7:0]              src_hmaster;
    logic                    src_hexokay;

    logic [N_PORTS-1:0]        slave_sel_d;
    logic [N_PORTS-1:0]        dst_hready;
    logic [N_PORTS-1:0]        dst_hready_resp;
    logic [N_PORTS-1:0]        dst_hresp;
    logic [N_PORTS*W_ADDR-1:0] dst_haddr;
    logic [N_PORTS-1:0]        dst_hwrite;
    logic [N_PORTS*2-1:0]      dst_htrans;
    logic [N_PORTS*3-1:0]      dst_hsize;
    logic [N_PORTS*3-1:0]      dst_hburst;
    logic [N_PORTS*4-1:0]      dst_hprot;
    logic [N_PORTS-1:0]        dst_hmastlock;
    logic [N_PORTS*W_DATA-1:0] dst_hwdata;
    logic [N_PORTS*W_DATA-1:0] dst_hrdata;
    logic [N_PORTS-1:0]        dst_hexcl;
    logic [N_PORTS*8-1:0]      dst_hmaster;
    logic [N_PORTS-1:0]        dst_hexokay;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata, src_hexcl, src_hmaster,
               dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay,
        output src_hready_resp, src_hresp, src_hrdata, src_hexokay, slave_sel_d,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl, dst_hmaster
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata, src_hexcl, src_hmaster,
               dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay,
        input  src_hready_resp, src_hresp, src_hrdata, src_hexokay, slave_sel_d,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl, dst_hmaster
    );
endinterface

// File: rtl/ahbl_splitter.sv
// 1:N AHB-Lite address decoder/splitter with priority decode, data-phase
// response muxing and a two-cycle ERROR response for unmapped addresses.
module ahbl_splitter #(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter int                        W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = {32'h4000_0000, 32'h0000_0000},
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter logic [N_PORTS-1:0]        CONN_MASK = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    ahbl_splitter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } err_state_e;

    err_state_e         state_q, state_d;
    logic [N_PORTS-1:0] sel_q, sel_d;
    logic [N_PORTS-1:0] hit, sel_a;
    logic               active;

    // Gated by reset so no slave sees a live transfer while the splitter is held in reset.
    assign active = bus.src_htrans[1] && rst_n;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            hit[i] = CONN_MASK[i] &&
                     ((bus.src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]);
        end
        sel_a = hit & (~hit + N_PORTS'(1));
    end

    assign bus.dst_hready    = {N_PORTS{bus.src_hready}};
    assign bus.dst_haddr     = {N_PORTS{bus.src_haddr}};
    assign bus.dst_hwrite    = {N_PORTS{bus.src_hwrite}};
    assign bus.dst_hsize     = {N_PORTS{bus.src_hsize}};
    assign bus.dst_hburst    = {N_PORTS{bus.src_hburst}};
    assign bus.dst_hprot     = {N_PORTS{bus.src_hprot}};
    assign bus.dst_hmastlock = {N_PORTS{bus.src_hmastlock}};
    assign bus.dst_hwdata    = {N_PORTS{bus.src_hwdata}};
    assign bus.dst_hexcl     = {N_PORTS{bus.src_hexcl}};
    assign bus.dst_hmaster   = {N_PORTS{bus.src_hmaster}};
    assign bus.slave_sel_d   = sel_q;

    always_comb begin
        bus.dst_htrans = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (active && sel_a[i]) begin
                bus.dst_htrans[i*2 +: 2] = bus.src_htrans;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (bus.src_hready) begin
            sel_d   = active ? sel_a : '0;
            state_d = (active && (sel_a == '0)) ? ST_ERR1 : ST_IDLE;
        end
        // ERR1 always has HREADYOUT low, so the second error cycle follows unconditionally.
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end
    end

    always_comb begin
        bus.src_hready_resp = 1'b1;
        bus.src_hresp       = 1'b0;
        bus.src_hrdata      = '0;
        bus.src_hexokay     = 1'b0;
        if (sel_q != '0) begin
            bus.src_hready_resp = 1'b0;
            for (int i = 0; i < N_PORTS; i++) begin
                if (sel_q[i]) begin
                    bus.src_hready_resp = bus.dst_hready_resp[i];
                    bus.src_hresp       = bus.dst_hresp[i];
                    bus.src_hrdata      = bus.dst_hrdata[i*W_DATA +: W_DATA];
                    bus.src_hexokay     = bus.dst_hexokay[i];
                end
            end
        end else begin
            case (state_q)
                ST_ERR1: begin
                    bus.src_hready_resp = 1'b0;
                    bus.src_hresp       = 1'b1;
                end
                ST_ERR2: begin
                    bus.src_hready_resp = 1'b1;
                    bus.src_hresp       = 1'b1;
                end
                default: begin
                    bus.src_hready_resp = 1'b1;
                    bus.src_hresp       = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_splitter.sv
// Directed self-checking bench for ahbl_splitter; HREADY is looped back from
// the splitter's HREADYOUT as in a single-master system.
module tb_ahbl_splitter;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errCount;

    ahbl_splitter_if #(.N_PORTS(2), .W_ADDR(32), .W_DATA(32)) bus ();

    ahbl_splitter #(
        .N_PORTS  (2),
        .W_ADDR   (32),
        .W_DATA   (32),
        .ADDR_MAP ({32'h4000_0000, 32'h0000_0000}),
        .ADDR_MASK({32'hF000_0000, 32'hF000_0000}),
        .CONN_MASK(2'b11)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    assign bus.src_hready = bus.src_hready_resp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic write,
                                 input logic [1:0] trans, input logic excl);
        bus.src_haddr     = addr;
        bus.src_hwrite    = write;
        bus.src_htrans    = trans;
        bus.src_hsize     = 3'b010;
        bus.src_hburst    = 3'b000;
        bus.src_hprot     = 4'b0011;
        bus.src_hmastlock = 1'b0;
        bus.src_hexcl     = excl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goIdle();
        @(negedge clk);
        applyStimulus(32'h0, 1'b0, 2'b00, 1'b0);
        nextCycle();
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        rst_n      = 1'b0;
        applyStimulus(32'h0, 1'b0, 2'b00, 1'b0);
        bus.src_hwdata      = 32'h0;
        bus.src_hmaster     = 8'h00;
        bus.dst_hready_resp = 2'b11;
        bus.dst_hresp       = 2'b00;
        bus.dst_hrdata      = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        bus.dst_hexokay     = 2'b00;
        #2;
        checkOutput("rst_hready_resp", bus.src_hready_resp, 1);
        checkOutput("rst_hresp", bus.src_hresp, 0);
        checkOutput("rst_sel", bus.slave_sel_d, 0);
        checkOutput("rst_hrdata", bus.src_hrdata, 0);
        checkOutput("rst_hexokay", bus.src_hexokay, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read to slave 0
        @(negedge clk);
        applyStimulus(32'h0000_0010, 1'b0, 2'b10, 1'b0);
        #1;
        checkOutput("rd0_dst_htrans", bus.dst_htrans, 4'b0010);
        checkOutput("rd0_dst_haddr", bus.dst_haddr, {2{32'h0000_0010}});
        checkOutput("rd0_dst_hready", bus.dst_hready, 2'b11);
        nextCycle();
        checkOutput("rd0_sel", bus.slave_sel_d, 2'b01);
        checkOutput("rd0_hrdata", bus.src_hrdata, 32'hCAFE_F00D);
        checkOutput("rd0_hready_resp", bus.src_hready_resp, 1);
        goIdle();
        checkOutput("rd0_sel_clear", bus.slave_sel_d, 0);
        checkOutput("rd0_hrdata_clear", bus.src_hrdata, 0);

        // Write to slave 1 with three wait states
        @(negedge clk);
        applyStimulus(32'h4000_0004, 1'b1, 2'b10, 1'b0);
        #1;
        checkOutput("wr1_dst_htrans", bus.dst_htrans, 4'b1000);
        nextCycle();
        checkOutput("wr1_sel", bus.slave_sel_d, 2'b10);
        @(negedge clk);
        applyStimulus(32'h0, 1'b0, 2'b00, 1'b0);
        bus.src_hwdata      = 32'h1234_5678;
        bus.dst_hready_resp = 2'b01;
        bus.dst_hresp       = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("wr1_wait_hready", bus.src_hready_resp, 0);
            checkOutput("wr1_wait_hresp", bus.src_hresp, 0);
            checkOutput("wr1_hwdata", bus.dst_hwdata, {2{32'h1234_5678}});
            checkOutput("wr1_wait_sel", bus.slave_sel_d, 2'b10);
            @(negedge clk);
        end
        bus.dst_hready_resp = 2'b11;
        bus.dst_hresp       = 2'b00;
        #1;
        checkOutput("wr1_done_hready", bus.src_hready_resp, 1);
        checkOutput("wr1_done_hwdata", bus.dst_hwdata, {2{32'h1234_5678}});
        nextCycle();
        checkOutput("wr1_sel_clear", bus.slave_sel_d, 0);

        // Unmapped access gives a two-cycle ERROR
        @(negedge clk);
        applyStimulus(32'h8000_0000, 1'b0, 2'b10, 1'b0);
        #1;
        checkOutput("err_dst_htrans", bus.dst_htrans, 0);
        nextCycle();
        checkOutput("err1_hready", bus.src_hready_resp, 0);
        checkOutput("err1_hresp", bus.src_hresp, 1);
        checkOutput("err1_sel", bus.slave_sel_d, 0);
        goIdle();
        checkOutput("err2_hready", bus.src_hready_resp, 1);
        checkOutput("err2_hresp", bus.src_hresp, 1);
        nextCycle();
        checkOutput("err_done_hready", bus.src_hready_resp, 1);
        checkOutput("err_done_hresp", bus.src_hresp, 0);

        // Back-to-back reads to different slaves
        @(negedge clk);
        applyStimulus(32'h0000_0000, 1'b0, 2'b10, 1'b0);
        nextCycle();
        checkOutput("b2b_sel_a", bus.slave_sel_d, 2'b01);
        @(negedge clk);
        applyStimulus(32'h4000_0000, 1'b0, 2'b10, 1'b0);
        #1;
        checkOutput("b2b_dst_htrans_b", bus.dst_htrans, 4'b1000);
        checkOutput("b2b_hrdata_a", bus.src_hrdata, 32'hCAFE_F00D);
        nextCycle();
        checkOutput("b2b_sel_b", bus.slave_sel_d, 2'b10);
        checkOutput("b2b_hrdata_b", bus.src_hrdata, 32'hDEAD_BEEF);
        goIdle();
        checkOutput("b2b_sel_clear", bus.slave_sel_d, 0);

        // Unmapped access followed by a hit launched during the error
        @(negedge clk);
        applyStimulus(32'h8000_0000, 1'b0, 2'b10, 1'b0);
        nextCycle();
        @(negedge clk);
        applyStimulus(32'h0000_0020, 1'b0, 2'b10, 1'b0);
        #1;
        checkOutput("errhit_err1_hready", bus.src_hready_resp, 0);
        nextCycle();
        checkOutput("errhit_err2_hresp", bus.src_hresp, 1);
        checkOutput("errhit_err2_sel", bus.slave_sel_d, 0);
        nextCycle();
        checkOutput("errhit_sel", bus.slave_sel_d, 2'b01);
        checkOutput("errhit_hresp", bus.src_hresp, 0);
        checkOutput("errhit_hrdata", bus.src_hrdata, 32'hCAFE_F00D);
        goIdle();

        // Slave-generated two-cycle ERROR passes through
        @(negedge clk);
        applyStimulus(32'h0000_0030, 1'b0, 2'b10, 1'b0);
        nextCycle();
        @(negedge clk);
        applyStimulus(32'h0, 1'b0, 2'b00, 1'b0);
        bus.dst_hready_resp = 2'b10;
        bus.dst_hresp       = 2'b01;
        #1;
        checkOutput("slverr1_hready", bus.src_hready_resp, 0);
        checkOutput("slverr1_hresp", bus.src_hresp, 1);
        @(negedge clk);
        bus.dst_hready_resp = 2'b11;
        #1;
        checkOutput("slverr2_hready", bus.src_hready_resp, 1);
        checkOutput("slverr2_hresp", bus.src_hresp, 1);
        nextCycle();
        bus.dst_hresp = 2'b00;
        #1;
        checkOutput("slverr_done_hresp", bus.src_hresp, 0);

        // Exclusive access sideband
        @(negedge clk);
        applyStimulus(32'h0000_0040, 1'b0, 2'b10, 1'b1);
        bus.src_hmaster = 8'h01;
        bus.dst_hexokay = 2'b01;
        #1;
        checkOutput("excl_dst_hexcl", bus.dst_hexcl, 2'b11);
        checkOutput("excl_dst_hmaster", bus.dst_hmaster, 16'h0101);
        nextCycle();
        checkOutput("excl_hexokay", bus.src_hexokay, 1);
        @(negedge clk);
        applyStimulus(32'h8000_0000, 1'b0, 2'b10, 1'b1);
        nextCycle();
        checkOutput("excl_err_hexokay", bus.src_hexokay, 0);
        checkOutput("excl_err_hresp", bus.src_hresp, 1);
        goIdle();
        nextCycle();
        bus.dst_hexokay = 2'b00;

        // Reset in the middle of a stalled read
        @(negedge clk);
        applyStimulus(32'h0000_0000, 1'b0, 2'b10, 1'b0);
        nextCycle();
        bus.dst_hready_resp = 2'b10;
        #1;
        checkOutput("midrst_stall", bus.src_hready_resp, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_hready", bus.src_hready_resp, 1);
        checkOutput("midrst_hresp", bus.src_hresp, 0);
        checkOutput("midrst_sel", bus.slave_sel_d, 0);
        checkOutput("midrst_dst_htrans", bus.dst_htrans, 0);
        applyStimulus(32'h0, 1'b0, 2'b00, 1'b0);
        bus.dst_hready_resp = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("postrst_sel", bus.slave_sel_d, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
